ahb_sram_slave: RTL and testbench
=================================

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 10; memory size is 2**ADDR_W bytes, organised as 32-bit words.
REQ-002 SHALL have parameter WAIT_STATES, default 1, range 0..7; the number of HREADYOUT-low cycles inserted in every OKAY data phase.
REQ-003 SHALL have a single clock and a synchronous, active-low reset.
REQ-004 HCLK  in  1  clock; all state changes on its rising edge.
REQ-005 HRESETn  in  1  reset; synchronous, active-low.
REQ-006 HSEL  in  1  slave select.
REQ-007 HADDR  in  32  byte address; bits above ADDR_W-1 are ignored (aliasing).
REQ-008 HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ encodings of the team AHB package.
REQ-009 HWRITE  in  1  1 = write.
REQ-010 HSIZE  in  3  transfer size.
REQ-011 HBURST, HPROT  in  3, 4  accepted and ignored.
REQ-012 HWDATA  in  32  write data, data phase.
REQ-013 HREADY  in  1  bus-level ready.
REQ-014 HREADYOUT  out  1  slave ready.
REQ-015 HRESP  out  1  OKAY=0, ERROR=1.
REQ-016 HRDATA  out  32  read data.

Function
REQ-017 An address phase SHALL be accepted on an edge where HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; HADDR, HWRITE and HSIZE are then captured.
REQ-018 IDLE, BUSY, or HSEL=0 with HREADY=1 SHALL produce a zero-wait OKAY response (HREADYOUT=1, HRESP=0) and no memory access.
REQ-019 A transfer SHALL be illegal when HSIZE>WORD, when HSIZE=HWORD and HADDR[0]=1, or when HSIZE=WORD and HADDR[1:0]!=0.
REQ-020 FSM states SHALL be IDLE, WAIT, ERR1 and ERR2.
REQ-021 A legal accepted transfer with WAIT_STATES>0 SHALL go to WAIT. A down-counter loaded with WAIT_STATES holds HREADYOUT=0 and HRESP=0 for exactly WAIT_STATES cycles, then presents HREADYOUT=1 for one completing cycle.
REQ-022 A legal accepted transfer with WAIT_STATES=0 SHALL complete in the first data-phase cycle (HREADYOUT=1).
REQ-023 An illegal accepted transfer SHALL go to ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), with no wait states, no memory write and HRDATA=0.
REQ-024 A write SHALL sample HWDATA in the completing cycle and update memory at that edge. Only byte lanes are written: B8 writes lane HADDR[1:0]; HWORD writes lanes 2*HADDR[1] and 2*HADDR[1]+1; WORD writes all four; little-endian.
REQ-025 A read SHALL drive HRDATA with the full aligned word at the captured address during the completing cycle. HRDATA SHALL be 0 in every other cycle.
REQ-026 A new address phase accepted in a completing cycle (incl. ERR2) SHALL start its data phase on the next cycle with no idle gap. Back-to-back pipelining is required.
REQ-027 A read whose data phase follows a write to the same word SHALL return the newly written data (write commits before the read completes).
REQ-028 Address phases presented while HREADY=0 SHALL be ignored.

Reset
REQ-029 While HRESETn=0 at an edge, the block SHALL enter IDLE with HREADYOUT=1, HRESP=0, HRDATA=0, counter=0 and the captured phase invalidated.
REQ-030 Reset mid-data-phase SHALL abandon the transfer with no memory write. Memory contents SHALL NOT be reset.

Verification
REQ-031 WAIT_STATES=1: WORD write 0xDEADBEEF to 0x010, then WORD read 0x010 -> each data phase shows 1 cycle HREADYOUT=0 then HREADYOUT=1; the read returns 0xDEADBEEF with HRESP=0.
REQ-032 B8 write 0xAA at 0x013 over word 0x11223344 -> WORD read 0x010 returns 0xAA223344.
REQ-033 HWORD access at 0x011 -> HRESP=1 with HREADYOUT=0, then HRESP=1 with HREADYOUT=1; the memory word is unchanged.
REQ-034 WAIT_STATES=0, back-to-back NONSEQ writes 0x0/0x4 followed by reads -> HREADYOUT stays 1 throughout and the reads return the written values.
REQ-035 Reset asserted during the WAIT of a write to 0x020 -> next cycle HREADYOUT=1 and HRESP=0; a later read of 0x020 returns the old value.
REQ-036 HTRANS=BUSY or IDLE with HSEL=1 -> HREADYOUT=1, HRESP=0, HRDATA=0 and memory unchanged.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
//   AHB-Lite slave in front of a 2**ADDR_W-byte SRAM built from 32-bit words.
//   Each legal transfer has a programmable number of wait states. Misaligned
//   or oversized transfers get a two-cycle ERROR response and never touch
//   memory. Address and data phases are pipelined, so a new address phase
//   accepted in a completing cycle starts its data phase on the next cycle.
//
// Parameters
//   ADDR_W       byte-address width of the memory (>= 3)
//   WAIT_STATES  HREADYOUT-low cycles per OKAY data phase (0..7)
//
// Ports
//   HCLK, HRESETn           clock; synchronous active-low reset
//   HSEL, HADDR, HTRANS,    address-phase inputs
//   HWRITE, HSIZE
//   HBURST, HPROT           accepted and ignored
//   HWDATA                  write data (data phase)
//   HREADY                  bus-level ready
//   HREADYOUT, HRESP        slave ready / response (OKAY=0, ERROR=1)
//   HRDATA                  read data; zero outside a completing read
module ahb_sram_slave #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   localparam int WORDS = 2 ** (ADDR_W - 2);

   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] TRANS_SEQ    = 2'b11;

   localparam logic [2:0] SIZE_BYTE  = 3'd0;
   localparam logic [2:0] SIZE_HWORD = 3'd1;
   localparam logic [2:0] SIZE_WORD  = 3'd2;

   typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

   // Legal sizes are BYTE/HWORD/WORD, naturally aligned.
   function automatic logic is_legal(input logic [2:0] size, input logic [1:0] a);
      logic ok;
      case (size)
         SIZE_BYTE:  ok = 1'b1;
         SIZE_HWORD: ok = (a[0] == 1'b0);
         SIZE_WORD:  ok = (a == 2'b00);
         default:    ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Little-endian byte-lane enables for a legal transfer.
   function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
      logic [3:0] be;
      case (size)
         SIZE_BYTE:  be = 4'b0001 << a;
         SIZE_HWORD: be = a[1] ? 4'b1100 : 4'b0011;
         default:    be = 4'b1111;
      endcase
      return be;
   endfunction

   state_t              state_q, state_d;
   logic [2:0]          cnt_q;
   logic [ADDR_W-1:0]   addr_p0;
   logic                write_p0;
   logic [2:0]          size_p0;
   logic [31:0]         mem [WORDS];

   logic                seq_trans;
   logic                take;
   logic                legal;
   logic                complete;
   logic                wr_en;
   logic [3:0]          be;

   logic                unused_ok;
   assign unused_ok = ^{HBURST, HPROT, HADDR[31:ADDR_W]};

   assign seq_trans = (HTRANS == TRANS_NONSEQ) || (HTRANS == TRANS_SEQ);
   // Only sample an address phase when our own previous data phase is done.
   assign take      = HSEL && HREADY && seq_trans && HREADYOUT;
   assign legal     = is_legal(HSIZE, HADDR[1:0]);
   // A legal data phase lives in WAIT; its last cycle is the one with cnt_q==0.
   // With WAIT_STATES=0 the counter loads 0, so the first cycle completes.
   assign complete  = (state_q == WAIT) && (cnt_q == 3'd0);
   // A reset on the completing edge abandons the write.
   assign wr_en     = complete && write_p0 && HRESETn;
   assign be        = byte_en(size_p0, addr_p0[1:0]);

   // State register
   always_ff @(posedge HCLK) begin
      if (!HRESETn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = IDLE;
         WAIT:    state_d = complete ? IDLE : WAIT;
         ERR1:    state_d = ERR2;
         ERR2:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (take) state_d = legal ? WAIT : ERR1;
   end

   // Output logic
   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      case (state_q)
         IDLE: begin HREADYOUT = 1'b1;     HRESP = 1'b0; end
         WAIT: begin HREADYOUT = complete; HRESP = 1'b0; end
         ERR1: begin HREADYOUT = 1'b0;     HRESP = 1'b1; end
         ERR2: begin HREADYOUT = 1'b1;     HRESP = 1'b1; end
         default: begin HREADYOUT = 1'b1;  HRESP = 1'b0; end
      endcase
   end

   // Wait-state down-counter
   always_ff @(posedge HCLK) begin
      if (!HRESETn)
         cnt_q <= 3'd0;
      else if (take)
         cnt_q <= legal ? 3'(WAIT_STATES) : 3'd0;
      else if ((state_q == WAIT) && (cnt_q != 3'd0))
         cnt_q <= cnt_q - 3'd1;
   end

   // Address phase -> data phase (p0): captured transfer attributes
   always_ff @(posedge HCLK) begin
      if (take) begin
         addr_p0  <= HADDR[ADDR_W-1:0];
         write_p0 <= HWRITE;
         size_p0  <= HSIZE;
      end
   end

   // Memory write commits on the completing edge, so a following read sees it.
   always_ff @(posedge HCLK) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[addr_p0[ADDR_W-1:2]][8*b +: 8] <= HWDATA[8*b +: 8];
         end
      end
   end

   always_comb begin
      HRDATA = 32'd0;
      if (complete && !write_p0) HRDATA = mem[addr_p0[ADDR_W-1:2]];
   end

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;

   logic        clk;
   logic        rst_n;
   logic        sel;
   logic        cur;      // 1: talk to the WAIT_STATES=1 slave, 0: the zero-wait slave
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic [31:0] hwdata;

   logic        hsel1, hsel0;
   logic        ready1, resp1, ready0, resp0;
   logic [31:0] rdata1, rdata0;
   logic        bus_ready, bus_resp;
   logic [31:0] bus_rdata;

   assign hsel1     = sel && cur;
   assign hsel0     = sel && !cur;
   assign bus_ready = cur ? ready1 : ready0;
   assign bus_resp  = cur ? resp1  : resp0;
   assign bus_rdata = cur ? rdata1 : rdata0;

   ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(1)) dut1 (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HWDATA(hwdata), .HREADY(ready1), .HREADYOUT(ready1), .HRESP(resp1),
      .HRDATA(rdata1)
   );

   ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HWDATA(hwdata), .HREADY(ready0), .HREADYOUT(ready0), .HRESP(resp0),
      .HRDATA(rdata0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic        err;
      logic        rd;
      logic [31:0] rdata;
      int          waits;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   xfer_id = 0;
   bit   dp = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Issue one address phase, push its expected response, wait for acceptance,
   // then present write data for its data phase.
   task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input logic err, input logic [31:0] rd);
      exp_t e;
      int   n;
      bit   acc;
      e.id    = xfer_id++;
      e.err   = err;
      e.rd    = !wr;
      e.rdata = (wr || err) ? 32'd0 : rd;
      e.waits = err ? 1 : (cur ? 1 : 0);
      exp_q.push_back(e);
      sel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 20) begin
         @(negedge clk);
         acc = bus_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout xfer#%0d: got not-ready expected ready within 20 cycles", e.id);
      end
      hwdata = wd;
   endtask

   task automatic idle(input int n);
      sel = 1'b0; htrans = 2'b00;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic busy(input logic [1:0] tr, input int n);
      sel = 1'b1; htrans = tr; hwrite = 1'b1; haddr = 32'h010; hsize = 3'd2;
      hwdata = 32'h0BAD_0BAD;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor / scoreboard
   exp_t cur_e;
   int   lows = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            dp   = 1'b0;
            lows = 0;
         end else begin
            if (dp) begin
               if (!bus_ready) begin
                  lows++;
                  chk($sformatf("xfer#%0d resp_while_wait", cur_e.id), {31'd0, bus_resp}, {31'd0, cur_e.err});
                  chk($sformatf("xfer#%0d rdata_while_wait", cur_e.id), bus_rdata, 32'd0);
                  if (lows > 16) begin
                     chk($sformatf("xfer#%0d wait_runaway", cur_e.id), 32'(lows), 32'(cur_e.waits));
                     dp = 1'b0;
                  end
               end else begin
                  chk($sformatf("xfer#%0d resp", cur_e.id), {31'd0, bus_resp}, {31'd0, cur_e.err});
                  chk($sformatf("xfer#%0d rdata", cur_e.id), bus_rdata, cur_e.rdata);
                  chk($sformatf("xfer#%0d wait_cycles", cur_e.id), 32'(lows), 32'(cur_e.waits));
                  dp = 1'b0;
               end
            end else begin
               chk("idle_ready", {31'd0, bus_ready}, 32'd1);
               chk("idle_resp", {31'd0, bus_resp}, 32'd0);
               chk("idle_rdata", bus_rdata, 32'd0);
            end
            if (bus_ready && sel && htrans[1]) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_accept: got accept expected none");
               end else begin
                  cur_e = exp_q.pop_front();
                  dp    = 1'b1;
                  lows  = 0;
               end
            end
         end
      end
   end

   // Stimulus
   initial begin
      int n;
      rst_n = 1'b0; sel = 1'b0; cur = 1'b1; htrans = 2'b00; hwrite = 1'b0;
      haddr = 32'd0; hsize = 3'd2; hburst = 3'd0; hprot = 4'd0; hwdata = 32'd0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      // WAIT_STATES=1 slave
      xfer(1'b1, 32'h010, 3'd2, 32'hDEADBEEF, 1'b0, 32'd0);
      xfer(1'b0, 32'h010, 3'd2, 32'd0,        1'b0, 32'hDEADBEEF);
      idle(3);

      xfer(1'b1, 32'h010, 3'd2, 32'h11223344, 1'b0, 32'd0);
      xfer(1'b1, 32'h013, 3'd0, 32'hAA776655, 1'b0, 32'd0);
      xfer(1'b0, 32'h010, 3'd2, 32'd0,        1'b0, 32'hAA223344);
      idle(2);

      xfer(1'b1, 32'h011, 3'd1, 32'hFFFFFFFF, 1'b1, 32'd0);
      xfer(1'b0, 32'h010, 3'd2, 32'd0,        1'b0, 32'hAA223344);
      xfer(1'b0, 32'h012, 3'd2, 32'd0,        1'b1, 32'd0);
      xfer(1'b1, 32'h010, 3'd3, 32'hFFFFFFFF, 1'b1, 32'd0);
      xfer(1'b1, 32'h012, 3'd1, 32'hBEEF0000, 1'b0, 32'd0);
      xfer(1'b0, 32'h410, 3'd2, 32'd0,        1'b0, 32'hBEEF3344);
      idle(2);

      busy(2'b01, 3);
      busy(2'b00, 2);
      xfer(1'b0, 32'h010, 3'd2, 32'd0, 1'b0, 32'hBEEF3344);
      idle(3);

      xfer(1'b1, 32'h020, 3'd2, 32'h12345678, 1'b0, 32'd0);
      idle(3);
      xfer(1'b1, 32'h020, 3'd2, 32'hCAFEF00D, 1'b0, 32'd0);
      sel = 1'b0; htrans = 2'b00; rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);
      xfer(1'b0, 32'h020, 3'd2, 32'd0, 1'b0, 32'h12345678);
      idle(3);

      // WAIT_STATES=0 slave, back-to-back
      cur = 1'b0;
      idle(2);
      xfer(1'b1, 32'h000, 3'd2, 32'h01020304, 1'b0, 32'd0);
      xfer(1'b1, 32'h004, 3'd2, 32'hA5A55A5A, 1'b0, 32'd0);
      xfer(1'b0, 32'h000, 3'd2, 32'd0,        1'b0, 32'h01020304);
      xfer(1'b0, 32'h004, 3'd2, 32'd0,        1'b0, 32'hA5A55A5A);
      xfer(1'b1, 32'h005, 3'd0, 32'h00003C00, 1'b0, 32'd0);
      xfer(1'b0, 32'h004, 3'd2, 32'd0,        1'b0, 32'hA5A53C5A);
      idle(3);

      n = 0;
      while ((exp_q.size() != 0 || dp) && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0 || dp) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
